// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage: RV32 opcodes, the registered
// decode payload, immediate generation and operand-usage/legality helpers.
// No ports; imported by id_stage_pipe.
package id_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  // Decoded fields held in the ID->EX register. The usage flags travel with
  // the instruction so operand refresh during a hold can honour them.
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
    logic       uses_rs1;
    logic       uses_rs2;
  } id_pipe_out_t;

  function automatic logic uses_rs1_f(input logic [6:0] opc);
    return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
  endfunction

  function automatic logic uses_rs2_f(input logic [6:0] opc);
    return (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
  endfunction

  function automatic logic uses_rd_f(input logic [6:0] opc);
    return !(opc == OPC_BRANCH || opc == OPC_STORE);
  endfunction

  function automatic logic is_legal_f(input logic [31:0] inst, input int num_regs);
    logic [6:0] opc;
    logic       ok;
    opc = inst[6:0];
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    if (uses_rs1_f(opc) && int'(inst[19:15]) >= num_regs) ok = 1'b0;
    if (uses_rs2_f(opc) && int'(inst[24:20]) >= num_regs) ok = 1'b0;
    if (uses_rd_f(opc)  && int'(inst[11:7])  >= num_regs) ok = 1'b0;
    return ok;
  endfunction

  // 32-bit RISC-V immediate; the stage sign-extends or truncates it to
  // its own data width.
  function automatic logic [31:0] gen_imm_f(input logic [31:0] inst);
    logic [31:0] imm;
    case (inst[6:0])
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_FENCE, OPC_SYSTEM:
        imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {inst[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/rf_wt.sv
// Register file with two combinational read ports and write-through.
// x0 reads zero and ignores writes; indices >= NUM_REGS read zero and
// ignore writes (RV32E). Synchronous active-high reset clears every entry.
// Ports: clk, rst, wr_en/wr_addr/wr_data (write port),
//        rd_addr_a/rd_data_a, rd_addr_b/rd_data_b (read ports).
module rf_wt #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [4:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [4:0]            rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [4:0]            rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic                  wr_ok;

  assign wr_ok = wr_en && (wr_addr != 5'd0) && (int'(wr_addr) < NUM_REGS);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  always_comb begin
    rd_data_a = '0;
    if (rd_addr_a != 5'd0 && int'(rd_addr_a) < NUM_REGS) begin
      if (wr_ok && wr_addr == rd_addr_a) rd_data_a = wr_data;
      else                               rd_data_a = mem[rd_addr_a[AW-1:0]];
    end
  end

  always_comb begin
    rd_data_b = '0;
    if (rd_addr_b != 5'd0 && int'(rd_addr_b) < NUM_REGS) begin
      if (wr_ok && wr_addr == rd_addr_b) rd_data_b = wr_data;
      else                               rd_data_b = mem[rd_addr_b[AW-1:0]];
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered RV32I/E decode stage between IF and EX.
// Accepts {in_pc,in_inst} under valid/ready, stalls on load-use hazards,
// drops in-flight and offered work on flush, and issues decoded fields plus
// register operands one cycle after acceptance. Operands of a held
// instruction pick up writebacks so EX never sees stale data.
// Ports: clk, rst (sync, active high); IF side in_valid/in_ready/in_pc/in_inst;
//        flush; writeback wb_en/wb_rd/wb_data; EX load info ex_ld_valid/ex_ld_rd;
//        EX side out_valid/out_ready and out_* payload; stall_cnt.
module id_stage_pipe
  import id_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [31:0]           in_inst,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  ex_ld_valid,
  input  logic [4:0]            ex_ld_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [6:0]            out_opcode,
  output logic [2:0]            out_funct3,
  output logic [6:0]            out_funct7,
  output logic [4:0]            out_rd,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [DATA_WIDTH-1:0] out_opr_a,
  output logic [DATA_WIDTH-1:0] out_opr_b,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic                  out_illegal,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  id_pipe_out_t          dec;
  id_pipe_out_t          pl;
  logic [31:0]           imm32;
  logic [DATA_WIDTH-1:0] imm_nxt;
  logic [DATA_WIDTH-1:0] rf_a;
  logic [DATA_WIDTH-1:0] rf_b;
  logic [DATA_WIDTH-1:0] opr_a_nxt;
  logic [DATA_WIDTH-1:0] opr_b_nxt;
  logic                  hazard;
  logic                  slot_free;

  always_comb begin
    dec          = '0;
    dec.opcode   = in_inst[6:0];
    dec.rd       = in_inst[11:7];
    dec.funct3   = in_inst[14:12];
    dec.rs1      = in_inst[19:15];
    dec.rs2      = in_inst[24:20];
    dec.funct7   = in_inst[31:25];
    dec.uses_rs1 = uses_rs1_f(in_inst[6:0]);
    dec.uses_rs2 = uses_rs2_f(in_inst[6:0]);
    dec.illegal  = !is_legal_f(in_inst, NUM_REGS);
  end

  assign imm32 = gen_imm_f(in_inst);

  // Sign-extend (or truncate) the 32-bit immediate to DATA_WIDTH.
  always_comb begin
    imm_nxt = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < 32) imm_nxt[i] = imm32[i[4:0]];
      else        imm_nxt[i] = imm32[31];
    end
  end

  rf_wt #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_rf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wb_en),
    .wr_addr   (wb_rd),
    .wr_data   (wb_data),
    .rd_addr_a (dec.rs1),
    .rd_data_a (rf_a),
    .rd_addr_b (dec.rs2),
    .rd_data_b (rf_b)
  );

  // Illegal instructions carry zero operands so a bad index never reaches EX.
  assign opr_a_nxt = (dec.uses_rs1 && !dec.illegal) ? rf_a : '0;
  assign opr_b_nxt = (dec.uses_rs2 && !dec.illegal) ? rf_b : '0;

  assign hazard = ex_ld_valid && (ex_ld_rd != 5'd0) &&
                  ((dec.uses_rs1 && ex_ld_rd == dec.rs1) ||
                   (dec.uses_rs2 && ex_ld_rd == dec.rs2));

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = !rst && (flush || (slot_free && !hazard));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      pl        <= '0;
      out_pc    <= '0;
      out_opr_a <= '0;
      out_opr_b <= '0;
      out_imm   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (slot_free) begin
      out_valid <= in_valid && !hazard;
      pl        <= dec;
      out_pc    <= in_pc;
      out_opr_a <= opr_a_nxt;
      out_opr_b <= opr_b_nxt;
      out_imm   <= imm_nxt;
    end else begin
      // Held: only the operands may change, and only those actually read.
      if (wb_en && pl.uses_rs1 && !pl.illegal && pl.rs1 != 5'd0 && wb_rd == pl.rs1)
        out_opr_a <= wb_data;
      if (wb_en && pl.uses_rs2 && !pl.illegal && pl.rs2 != 5'd0 && wb_rd == pl.rs2)
        out_opr_b <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && !flush && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign out_opcode  = pl.opcode;
  assign out_funct3  = pl.funct3;
  assign out_funct7  = pl.funct7;
  assign out_rd      = pl.rd;
  assign out_rs1     = pl.rs1;
  assign out_rs2     = pl.rs2;
  assign out_illegal = pl.illegal;

endmodule
